// File: rtl/volume_request_arbiter.sv
// Round-robin arbiter that shares one firmware block-transfer channel among drive-emulation volumes.
// Optional macro VOLUME_ARB_TIMEOUT_EN adds a host-ack timeout with a sticky timeout_err output.
module volume_request_arbiter #(
    parameter int NUM_VOLUMES    = 2,
    parameter int LBA_WIDTH      = 32,
    parameter int BLK_CNT_WIDTH  = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    localparam int VW            = $clog2(NUM_VOLUMES)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_VOLUMES-1:0]             vol_mounted,
    input  logic [NUM_VOLUMES-1:0]             vol_rd,
    input  logic [NUM_VOLUMES-1:0]             vol_wr,
    input  logic [NUM_VOLUMES*LBA_WIDTH-1:0]   vol_lba,
    input  logic [NUM_VOLUMES*BLK_CNT_WIDTH-1:0] vol_blk_cnt,
    output logic [NUM_VOLUMES-1:0]             vol_ack,
    output logic                               host_req,
    output logic                               host_rd,
    output logic                               host_wr,
    output logic [VW-1:0]                      host_vol,
    output logic [LBA_WIDTH-1:0]               host_lba,
    output logic [BLK_CNT_WIDTH-1:0]           host_blk_cnt,
    input  logic                               host_ack,
`ifdef VOLUME_ARB_TIMEOUT_EN
    output logic                               timeout_err,
`endif
    output logic                               busy
);

    typedef enum logic [1:0] {IDLE, REQ, REL, VACK} state_t;

    state_t                     state, state_d;
    logic [VW-1:0]              last_grant, last_grant_d;
    logic [VW-1:0]              host_vol_d;
    logic [LBA_WIDTH-1:0]       host_lba_d;
    logic [BLK_CNT_WIDTH-1:0]   host_blk_cnt_d;
    logic                       host_rd_d, host_wr_d;
    logic [NUM_VOLUMES-1:0]     eligible;
    logic                       grant_found;
    logic [VW-1:0]              grant_idx;
    int                         cand;
    logic                       granted_active;

`ifdef VOLUME_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr, tmr_d;
    logic          timeout_err_d;
`endif

    // Walk offsets from the far end down so the nearest eligible volume after last_grant wins.
    always_comb begin
        eligible    = vol_mounted & (vol_rd | vol_wr);
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = NUM_VOLUMES; i >= 1; i--) begin
            cand = (int'(last_grant) + i) % NUM_VOLUMES;
            if (eligible[cand[VW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[VW-1:0];
            end
        end
    end

    assign granted_active = vol_rd[host_vol] | vol_wr[host_vol];

    always_comb begin
        state_d        = state;
        last_grant_d   = last_grant;
        host_vol_d     = host_vol;
        host_lba_d     = host_lba;
        host_blk_cnt_d = host_blk_cnt;
        host_rd_d      = host_rd;
        host_wr_d      = host_wr;
`ifdef VOLUME_ARB_TIMEOUT_EN
        tmr_d          = tmr;
        timeout_err_d  = timeout_err;
`endif
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_d        = REQ;
                    last_grant_d   = grant_idx;
                    host_vol_d     = grant_idx;
                    host_lba_d     = vol_lba[int'(grant_idx)*LBA_WIDTH +: LBA_WIDTH];
                    host_blk_cnt_d = vol_blk_cnt[int'(grant_idx)*BLK_CNT_WIDTH +: BLK_CNT_WIDTH];
                    host_rd_d      = vol_rd[grant_idx];
                    host_wr_d      = vol_wr[grant_idx] & ~vol_rd[grant_idx];
`ifdef VOLUME_ARB_TIMEOUT_EN
                    tmr_d          = '0;
`endif
                end
            end
            REQ: begin
                if (host_ack) begin
                    state_d = REL;
                end
`ifdef VOLUME_ARB_TIMEOUT_EN
                else if (tmr == TW'(TIMEOUT_CYCLES)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmr_d = tmr + TW'(1);
                end
`endif
            end
            // A volume that withdrew while the host was busy gets no acknowledge.
            REL: begin
                if (!host_ack) begin
                    state_d = granted_active ? VACK : IDLE;
                end
            end
            VACK: begin
                if (!granted_active) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= VW'(NUM_VOLUMES - 1);
            host_vol     <= '0;
            host_lba     <= '0;
            host_blk_cnt <= '0;
            host_rd      <= 1'b0;
            host_wr      <= 1'b0;
`ifdef VOLUME_ARB_TIMEOUT_EN
            tmr          <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            last_grant   <= last_grant_d;
            host_vol     <= host_vol_d;
            host_lba     <= host_lba_d;
            host_blk_cnt <= host_blk_cnt_d;
            host_rd      <= host_rd_d;
            host_wr      <= host_wr_d;
`ifdef VOLUME_ARB_TIMEOUT_EN
            tmr          <= tmr_d;
            timeout_err  <= timeout_err_d;
`endif
        end
    end

    // Handshake outputs decode straight from the state register so reset clears them at once.
    always_comb begin
        vol_ack = '0;
        if (state == VACK) begin
            vol_ack[host_vol] = 1'b1;
        end
    end

    assign host_req = (state == REQ);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_volume_request_arbiter.sv
// Self-checking bench for volume_request_arbiter: vector table, hand-written corner sequences,
// and randomized transactions checked against a transaction-level reference model.
module tb_volume_request_arbiter;

    localparam int NV = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    vol_mounted, vol_rd, vol_wr;
    logic [63:0]   vol_lba;
    logic [11:0]   vol_blk_cnt;
    logic [1:0]    vol_ack;
    logic          host_req, host_rd, host_wr, host_ack, busy;
    logic [0:0]    host_vol;
    logic [31:0]   host_lba;
    logic [5:0]    host_blk_cnt;
`ifdef VOLUME_ARB_TIMEOUT_EN
    logic          timeout_err;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    volume_request_arbiter #(
        .NUM_VOLUMES(NV), .LBA_WIDTH(32), .BLK_CNT_WIDTH(6), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .vol_mounted(vol_mounted), .vol_rd(vol_rd), .vol_wr(vol_wr),
        .vol_lba(vol_lba), .vol_blk_cnt(vol_blk_cnt), .vol_ack(vol_ack),
        .host_req(host_req), .host_rd(host_rd), .host_wr(host_wr),
        .host_vol(host_vol), .host_lba(host_lba), .host_blk_cnt(host_blk_cnt),
        .host_ack(host_ack),
`ifdef VOLUME_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] r, input logic [1:0] w,
                                 input logic [31:0] l0, input logic [31:0] l1,
                                 input logic [5:0] c0, input logic [5:0] c1);
        vol_mounted = m;
        vol_rd      = r;
        vol_wr      = w;
        vol_lba     = {l1, l0};
        vol_blk_cnt = {c1, c0};
    endtask

    task automatic applyReset();
        host_ack = 1'b0;
        applyStimulus(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 6'h0, 6'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  m, r, w;
        logic [31:0] l0, l1;
        logic [5:0]  c0, c1;
        logic        exp_req, exp_vol, exp_rd, exp_wr;
        logic [31:0] exp_lba;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs[7];

    logic [1:0]  m, r, w;
    logic [31:0] l0, l1, model_lba;
    logic [5:0]  c0, c1;
    logic        model_last, g, g_found, withdraw, both_ack, held;
    int          grants[$];
    logic        prev_req;

    initial begin
        vecs[0] = '{2'b11, 2'b01, 2'b00, 32'hA0, 32'hB1, 6'd3, 6'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0, 6'd3};
        vecs[1] = '{2'b11, 2'b10, 2'b00, 32'hA0, 32'hB1, 6'd3, 6'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB1, 6'd4};
        vecs[2] = '{2'b11, 2'b00, 2'b11, 32'h11, 32'h22, 6'd7, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11, 6'd7};
        vecs[3] = '{2'b11, 2'b01, 2'b01, 32'h55, 32'h66, 6'd9, 6'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h55, 6'd9};
        vecs[4] = '{2'b10, 2'b11, 2'b00, 32'h77, 32'h88, 6'd2, 6'd63, 1'b1, 1'b1, 1'b1, 1'b0, 32'h88, 6'd63};
        vecs[5] = '{2'b11, 2'b00, 2'b10, 32'h1, 32'hFFFF_FFFF, 6'd0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 6'd5};
        vecs[6] = '{2'b00, 2'b11, 2'b11, 32'h9, 32'h9, 6'd9, 6'd9, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'd0};

        // Reset state
        applyReset();
        checkOutput("rst_host_req", host_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_vol_ack", vol_ack, 0);
        checkOutput("rst_host_vol", host_vol, 0);
        checkOutput("rst_host_lba", host_lba, 0);
`ifdef VOLUME_ARB_TIMEOUT_EN
        checkOutput("rst_timeout_err", timeout_err, 0);
`endif

        // Vector table, each entry starting from reset so volume 0 has priority
        for (int i = 0; i < 7; i++) begin
            applyReset();
            applyStimulus(vecs[i].m, vecs[i].r, vecs[i].w, vecs[i].l0, vecs[i].l1, vecs[i].c0, vecs[i].c1);
            step();
            checkOutput($sformatf("vec%0d_req", i), host_req, vecs[i].exp_req);
            checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                checkOutput($sformatf("vec%0d_vol", i), host_vol, vecs[i].exp_vol);
                checkOutput($sformatf("vec%0d_rd", i), host_rd, vecs[i].exp_rd);
                checkOutput($sformatf("vec%0d_wr", i), host_wr, vecs[i].exp_wr);
                checkOutput($sformatf("vec%0d_lba", i), host_lba, vecs[i].exp_lba);
                checkOutput($sformatf("vec%0d_cnt", i), host_blk_cnt, vecs[i].exp_cnt);
            end
        end

        // Single read on volume 0 through the full handshake
        applyReset();
        applyStimulus(2'b01, 2'b01, 2'b00, 32'h123, 32'h0, 6'd1, 6'd0);
        step();
        checkOutput("rd_req", host_req, 1);
        checkOutput("rd_vol", host_vol, 0);
        checkOutput("rd_rd", host_rd, 1);
        checkOutput("rd_lba", host_lba, 32'h123);
        host_ack = 1'b1;
        step();
        checkOutput("rd_req_drop", host_req, 0);
        checkOutput("rd_no_early_ack", vol_ack, 0);
        host_ack = 1'b0;
        step();
        checkOutput("rd_vol_ack", vol_ack, 2'b01);
        vol_rd = 2'b00;
        step();
        checkOutput("rd_ack_drop", vol_ack, 0);
        checkOutput("rd_idle", busy, 0);

        // Unmounted volume is ignored until it is mounted
        applyReset();
        applyStimulus(2'b01, 2'b10, 2'b00, 32'h0, 32'h42, 6'd0, 6'd2);
        held = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (host_req) held = 1'b1;
        end
        checkOutput("unmounted_no_req", held, 0);
        vol_mounted = 2'b11;
        step();
        checkOutput("mounted_req", host_req, 1);
        checkOutput("mounted_vol", host_vol, 1);

        // Withdrawal during REQ: host transaction completes, no vol_ack
        applyReset();
        applyStimulus(2'b11, 2'b00, 2'b10, 32'h0, 32'h77, 6'd0, 6'd3);
        step();
        checkOutput("wd_vol", host_vol, 1);
        vol_wr = 2'b00;
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!host_req) held = 1'b0;
        end
        checkOutput("wd_req_held", held, 1);
        host_ack = 1'b1;
        step();
        checkOutput("wd_req_drop", host_req, 0);
        host_ack = 1'b0;
        step();
        checkOutput("wd_no_ack", vol_ack, 0);
        checkOutput("wd_idle", busy, 0);
        step();
        checkOutput("wd_no_ack_later", vol_ack, 0);

        // Reset while in VACK drops everything immediately
        applyReset();
        applyStimulus(2'b11, 2'b01, 2'b00, 32'h5, 32'h6, 6'd1, 6'd1);
        step();
        host_ack = 1'b1;
        step();
        host_ack = 1'b0;
        step();
        checkOutput("rv_vack", vol_ack, 2'b01);
        vol_rd = 2'b11;
        reset = 1'b1;
        #1;
        checkOutput("rv_ack_clr", vol_ack, 0);
        checkOutput("rv_req_clr", host_req, 0);
        checkOutput("rv_busy_clr", busy, 0);
        #2;
        reset = 1'b0;
        step();
        checkOutput("rv_regrant_req", host_req, 1);
        checkOutput("rv_regrant_vol", host_vol, 0);

        // Round robin with both volumes writing continuously; volumes drop request on vol_ack
        applyReset();
        applyStimulus(2'b11, 2'b00, 2'b11, 32'h10, 32'h20, 6'd1, 6'd2);
        grants = {};
        both_ack = 1'b0;
        prev_req = 1'b0;
        for (int cyc = 0; cyc < 200 && grants.size() < 4; cyc++) begin
            step();
            if (vol_ack == 2'b11) both_ack = 1'b1;
            if (host_req && !prev_req) grants.push_back(int'(host_vol));
            prev_req = host_req;
            host_ack = host_req;
            vol_wr   = 2'b11 & ~vol_ack;
        end
        checkOutput("rr_count", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++)
            checkOutput($sformatf("rr_grant%0d", i), grants[i], i % 2);
        checkOutput("rr_single_ack", both_ack, 0);
        host_ack = 1'b0;

`ifdef VOLUME_ARB_TIMEOUT_EN
        // Host never acks: timeout after 17 cycles, then volume 1 is granted
        applyReset();
        applyStimulus(2'b11, 2'b11, 2'b00, 32'h1, 32'h2, 6'd1, 6'd2);
        step();
        checkOutput("to_req", host_req, 1);
        repeat (16) step();
        checkOutput("to_req_still", host_req, 1);
        step();
        checkOutput("to_req_drop", host_req, 0);
        checkOutput("to_err", timeout_err, 1);
        checkOutput("to_no_ack", vol_ack, 0);
        step();
        checkOutput("to_next_vol", host_vol, 1);
        checkOutput("to_next_req", host_req, 1);
        checkOutput("to_err_sticky", timeout_err, 1);
`endif

        // Randomized transactions against a transaction-level model
        applyReset();
        model_last = 1'b1;
        model_lba  = 32'h0;
        for (int it = 0; it < 60; it++) begin
            m = 2'($urandom); r = 2'($urandom); w = 2'($urandom);
            l0 = $urandom; l1 = $urandom; c0 = 6'($urandom); c1 = 6'($urandom);
            checkOutput("rand_lba_hold", host_lba, model_lba);
            applyStimulus(m, r, w, l0, l1, c0, c1);
            g_found = 1'b0;
            g = 1'b0;
            for (int k = 1; k <= NV; k++) begin
                logic cidx;
                cidx = 1'((int'(model_last) + k) % NV);
                if (!g_found && m[cidx] && (r[cidx] || w[cidx])) begin
                    g_found = 1'b1;
                    g = cidx;
                end
            end
            step();
            if (!g_found) begin
                checkOutput("rand_no_req", host_req, 0);
            end else begin
                checkOutput("rand_req", host_req, 1);
                checkOutput("rand_vol", host_vol, g);
                checkOutput("rand_rd", host_rd, r[g]);
                checkOutput("rand_wr", host_wr, w[g] && !r[g]);
                checkOutput("rand_lba", host_lba, g ? l1 : l0);
                checkOutput("rand_cnt", host_blk_cnt, g ? c1 : c0);
                model_last = g;
                model_lba  = g ? l1 : l0;
                withdraw = ($urandom_range(0, 3) == 0);
                if (withdraw) begin
                    r[g] = 1'b0;
                    w[g] = 1'b0;
                    applyStimulus(m, r, w, l0, l1, c0, c1);
                end
                repeat ($urandom_range(0, 4)) step();
                checkOutput("rand_req_hold", host_req, 1);
                host_ack = 1'b1;
                step();
                checkOutput("rand_req_drop", host_req, 0);
                repeat ($urandom_range(0, 2)) step();
                host_ack = 1'b0;
                step();
                checkOutput("rand_vol_ack", vol_ack, withdraw ? 2'b00 : (2'b01 << g));
            end
            applyStimulus(m, 2'b00, 2'b00, l0, l1, c0, c1);
            step();
            checkOutput("rand_end_busy", busy, 0);
            checkOutput("rand_end_ack", vol_ack, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/volume_request_arbiter.md
Name: volume_request_arbiter

Overview:
- Shares the single firmware-serviced block-transfer channel among NUM_VOLUMES drive-emulation volumes.
- Each volume raises a level rd/wr request with lba/blk_cnt. The arbiter grants one volume at a time, round-robin, and presents its request to the PicoSoC-side register file as one host request.
- It completes a four-phase handshake on both sides.
- It sits between the drive emulators' volume signals and the PicoSoC peripheral's per-volume register block.

Parameters:
- NUM_VOLUMES, 2, number of requesting volumes (2..8).
- LBA_WIDTH, 32, block address width.
- BLK_CNT_WIDTH, 6, block count width.
- TIMEOUT_CYCLES, 50_000_000, host-ack timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vol_mounted  in  NUM_VOLUMES  volume mounted; requests from unmounted volumes are ignored.
- vol_rd  in  NUM_VOLUMES  read request, level.
- vol_wr  in  NUM_VOLUMES  write request, level.
- vol_lba  in  NUM_VOLUMES*LBA_WIDTH  per-volume LBA, packed with volume 0 in the LSBs.
- vol_blk_cnt  in  NUM_VOLUMES*BLK_CNT_WIDTH  per-volume block count, packed.
- vol_ack  out  NUM_VOLUMES  completion acknowledge to the granted volume.
- host_req  out  1  request pending to firmware.
- host_rd  out  1  latched read flag.
- host_wr  out  1  latched write flag.
- host_vol  out  $clog2(NUM_VOLUMES)  granted volume index.
- host_lba  out  LBA_WIDTH  latched LBA.
- host_blk_cnt  out  BLK_CNT_WIDTH  latched block count.
- host_ack  in  1  firmware completion, level.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE.
  - All outputs 0; host_vol=0.
  - Round-robin pointer last_grant = NUM_VOLUMES-1, so volume 0 wins first.
  - Reset mid-transaction abandons it immediately; vol_ack and host_req drop in the same cycle reset asserts.
- Eligible volume i: vol_mounted[i] & (vol_rd[i] | vol_wr[i]).
- Arbitration: in IDLE, pick the first eligible index searching upward from last_grant+1, with wrap-around modulo NUM_VOLUMES.
- States:
  - IDLE: if any volume is eligible at cycle N, then at N+1:
    - Latch host_vol, host_lba, host_blk_cnt.
    - host_rd = vol_rd[g]; host_wr = vol_wr[g] & ~vol_rd[g]. rd wins when both are high.
    - Set last_grant=g, assert host_req, go to REQ.
    - If no volume is eligible, stay in IDLE.
  - REQ: host_req=1; latched fields held stable. On host_ack=1: host_req<=0, go to REL.
  - REL: wait for host_ack=0. Then:
    - If vol_rd[g]|vol_wr[g] is still high: vol_ack[g]<=1, go to VACK.
    - Otherwise (requester withdrew): go to IDLE with no vol_ack.
  - VACK: vol_ack[g]=1 until vol_rd[g]=0 and vol_wr[g]=0. Then vol_ack[g]<=0, go to IDLE.
- At most one vol_ack bit is high at any time.
- Request withdrawal:
  - A request dropped during REQ is not retracted; the host transaction completes.
  - Only the vol_ack is suppressed (REL path).
- Unmount during a transaction does not abort it.
- host_lba, host_blk_cnt, host_rd, host_wr and host_vol change only on the IDLE->REQ transition. They retain their last values in IDLE.
- Minimum turnaround: one IDLE cycle between transactions. Back-to-back grants alternate when both volumes request continuously.
- host_ack high while in IDLE is ignored.

Optional Feature:
- Macro: VOLUME_ARB_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to REQ and increments each cycle in REQ.
  - If it reaches TIMEOUT_CYCLES, then on the next cycle: host_req<=0, output timeout_err (1 bit, sticky) <=1, and state goes to IDLE with no vol_ack.
  - last_grant is still updated, so the other volume gets the next grant.
  - timeout_err clears only on reset.
  - host_ack arriving in the same cycle as expiry takes precedence (normal completion).
- Undefined: no counter, no timeout_err port; REQ waits indefinitely.

Test Plan:
- Single read, volume 0: mounted=01, vol_rd=01, lba0=0x00000123, blk_cnt0=1.
  - Expect host_req=1 one cycle later, host_vol=0, host_rd=1, host_lba=0x123.
  - host_ack pulse high then low -> vol_ack=01 one cycle after host_ack falls.
  - Drop vol_rd -> vol_ack=00, busy=0 next cycle.
- Round-robin: both volumes continuously request wr; firmware acks each.
  - Expect host_vol sequence 0,1,0,1.
  - vol_ack never has both bits set.
- Unmounted ignore: mounted=01, vol_rd=10 -> host_req stays 0 for 100 cycles.
  - Then mounted=11 -> host_req=1, host_vol=1.
- Withdrawal: volume 1 drops vol_wr while in REQ.
  - Expect host_req held until host_ack=1.
  - After host_ack falls: no vol_ack pulse, return to IDLE.
- Reset mid-operation: assert reset while in VACK.
  - vol_ack=00, host_req=0, busy=0 in the same cycle.
  - After release with both requesting -> host_vol=0.
- With VOLUME_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: request volume 0, never assert host_ack.
  - host_req falls 17 cycles after assertion.
  - timeout_err=1; the next pending volume 1 is granted.
